// File: rtl/arb_phase_sequencer_if.sv
// Vertmat port-B bus: relax and printer request sets in, one muxed memory request out.
interface arb_phase_sequencer_if #(
    parameter int PRED_WIDTH = 5,
    parameter int VERT_WIDTH = 25
);
    logic [PRED_WIDTH:0] rlx_addr_b;
    logic [VERT_WIDTH:0] rlx_data_b;
    logic                rlx_we_b;
    logic [PRED_WIDTH:0] prt_addr_b;
    logic [VERT_WIDTH:0] prt_data_b;
    logic                prt_we_b;
    logic [PRED_WIDTH:0] vertmat_addr_b;
    logic [VERT_WIDTH:0] vertmat_data_b;
    logic                vertmat_we_b;

    // slave: the sequencer, which owns the port and grants it to a client
    modport slave (
        input  rlx_addr_b, rlx_data_b, rlx_we_b,
        input  prt_addr_b, prt_data_b, prt_we_b,
        output vertmat_addr_b, vertmat_data_b, vertmat_we_b
    );
    modport master (
        output rlx_addr_b, rlx_data_b, rlx_we_b,
        output prt_addr_b, prt_data_b, prt_we_b,
        input  vertmat_addr_b, vertmat_data_b, vertmat_we_b
    );
endinterface

// File: rtl/arb_phase_sequencer.sv
// Arbitrage core phase controller: PASSES relax passes, then one print, with
// port-B ownership, a one-deep update queue and a per-phase watchdog.
module arb_phase_sequencer #(
    parameter int          PRED_WIDTH  = 5,
    parameter int          VERT_WIDTH  = 25,
    parameter int          PASSES      = 63,
    parameter int          TIMEOUT     = 4095,
    parameter logic [15:0] ROUNDS_INIT = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  update_valid,
    input  logic                  relax_done,
    input  logic                  print_done,
    output logic                  relax_reset,
    output logic                  print_reset,
    arb_phase_sequencer_if.slave  port_b,
    output logic                  busy,
    output logic [PRED_WIDTH:0]   pass_cnt,
    output logic [15:0]           rounds,
    output logic                  dropped,
    output logic                  timeout_err
);
    localparam int                  WDW       = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]      WD_LIMIT  = WDW'(TIMEOUT);
    localparam logic [PRED_WIDTH:0] LAST_PASS = (PRED_WIDTH + 1)'(PASSES - 1);

    typedef enum logic [2:0] {IDLE, RLX_RST, RELAX, PRT_RST, PRINT} state_t;

    state_t              state, state_nxt;
    logic [WDW-1:0]      wdog, wdog_nxt;
    logic [PRED_WIDTH:0] pass_nxt;
    logic [15:0]         rounds_nxt;
    logic                pending, pending_nxt;
    logic                dropped_nxt, timeout_nxt;
    logic                wdog_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wdog        <= '0;
            pass_cnt    <= '0;
            rounds      <= ROUNDS_INIT;
            pending     <= 1'b0;
            dropped     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            wdog        <= wdog_nxt;
            pass_cnt    <= pass_nxt;
            rounds      <= rounds_nxt;
            pending     <= pending_nxt;
            dropped     <= dropped_nxt;
            timeout_err <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wdog_nxt    = wdog;
        pass_nxt    = pass_cnt;
        rounds_nxt  = rounds;
        pending_nxt = pending;
        dropped_nxt = dropped;
        timeout_nxt = timeout_err;
        wdog_hit    = (wdog == WD_LIMIT);

        // Mid-round updates queue one deep; round-end and abort paths override below.
        if (state != IDLE && update_valid) begin
            if (pending) dropped_nxt = 1'b1;
            else         pending_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (update_valid || pending) begin
                    pending_nxt = 1'b0;
                    state_nxt   = RLX_RST;
                end
            end
            RLX_RST: begin
                wdog_nxt  = '0;
                state_nxt = RELAX;
            end
            RELAX: begin
                wdog_nxt = wdog + 1'b1;
                if (relax_done) begin
                    if (pass_cnt == LAST_PASS) begin
                        pass_nxt  = '0;
                        state_nxt = PRT_RST;
                    end else begin
                        pass_nxt  = pass_cnt + 1'b1;
                        state_nxt = RLX_RST;
                    end
                end else if (wdog_hit) begin
                    timeout_nxt = 1'b1;
                    pass_nxt    = '0;
                    pending_nxt = 1'b0;
                    wdog_nxt    = '0;
                    state_nxt   = IDLE;
                end
            end
            PRT_RST: begin
                wdog_nxt  = '0;
                state_nxt = PRINT;
            end
            PRINT: begin
                wdog_nxt = wdog + 1'b1;
                if (print_done) begin
                    rounds_nxt = rounds + 1'b1;
                    if (pending || update_valid) begin
                        // a same-cycle update is absorbed by the round that starts now
                        pending_nxt = 1'b0;
                        dropped_nxt = dropped;
                        state_nxt   = RLX_RST;
                    end else begin
                        state_nxt   = IDLE;
                    end
                end else if (wdog_hit) begin
                    timeout_nxt = 1'b1;
                    pass_nxt    = '0;
                    pending_nxt = 1'b0;
                    wdog_nxt    = '0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign relax_reset = reset || (state != RELAX);
    assign print_reset = reset || (state != PRINT);

    // Write enable only reaches memory in the working states, never in a reset cycle.
    always_comb begin
        port_b.vertmat_addr_b = '0;
        port_b.vertmat_data_b = '0;
        port_b.vertmat_we_b   = 1'b0;
        if (!reset) begin
            case (state)
                RLX_RST, RELAX: begin
                    port_b.vertmat_addr_b = port_b.rlx_addr_b;
                    port_b.vertmat_data_b = port_b.rlx_data_b;
                    port_b.vertmat_we_b   = (state == RELAX) && port_b.rlx_we_b;
                end
                PRT_RST, PRINT: begin
                    port_b.vertmat_addr_b = port_b.prt_addr_b;
                    port_b.vertmat_data_b = port_b.prt_data_b;
                    port_b.vertmat_we_b   = (state == PRINT) && port_b.prt_we_b;
                end
                default: ;
            endcase
        end
    end
endmodule
